fifo_burst_drain: RTL
=====================

# fifo_burst_drain

Read-side controller for the team's synchronous BRAM FIFO. It pops bytes from the FIFO's registered read port, taking the one-cycle read latency into account. It re-emits them on a valid/ready output stream in fixed-length bursts framed with `m_last`. A flush request drains a partial burst. It sits between the FIFO and any downstream consumer that applies backpressure.

## Interface
- `DATA_W`, default 8: data width; must match the FIFO data width.
- `BUF_WIDTH`, default 3: FIFO pointer width; the FIFO depth is 2**BUF_WIDTH.
- `BURST_LEN`, default 4: beats per normal burst; legal range 1 to 2**BUF_WIDTH.
- `clk`, in, 1: single system clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_count`, in, BUF_WIDTH+1: FIFO occupancy.
- `fifo_data`, in, DATA_W: FIFO registered read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`, out, 1: FIFO pop request.
- `flush`, in, 1: one-cycle pulse; drain a partial burst.
- `m_data`, out, DATA_W: output beat data.
- `m_valid`, out, 1: output beat valid.
- `m_last`, out, 1: final beat of the current burst.
- `m_ready`, in, 1: downstream accept.
- `busy`, out, 1: high while a burst is in progress.

## Operation
- Two states, IDLE and BURST.
- **IDLE to BURST, normal start:** when `fifo_count >= BURST_LEN`.
  - Latch `issue_rem = BURST_LEN` and `out_rem = BURST_LEN`.
- **IDLE to BURST, flush start:** when `flush && !fifo_empty` and the normal condition is false.
  - Latch `issue_rem = out_rem = fifo_count`.
- **Flush in other cases:**
  - `flush` with `fifo_empty` is ignored.
  - `flush` in BURST is ignored and is not queued.
- **In BURST, pop rule:** assert `fifo_rd_en` iff all of the following hold:
  - `issue_rem != 0`;
  - `!fifo_empty`;
  - `skid_occ + inflight - pop_now < 2`, where `pop_now = m_valid && m_ready`.
- **Counters:**
  - Each `fifo_rd_en` decrements `issue_rem`.
  - `inflight` is `fifo_rd_en` delayed one cycle.
  - When `inflight` is high, `fifo_data` is written into the 2-entry skid buffer.
- **Output side:**
  - `m_valid = (skid_occ != 0)`; `m_data` is the skid head.
  - `m_last = m_valid && (out_rem == 1)`.
  - Each handshake (`m_valid && m_ready`) decrements `out_rem`.
- **Burst completion:** the handshake with `m_last` high returns the block to IDLE. The next burst start is evaluated in the following cycle, so there is a minimum of one IDLE cycle between bursts.
- **Handshake rules:**
  - Once `m_valid` is high, `m_data` and `m_last` hold stable until accepted.
  - `m_valid` never drops without a handshake, except on reset.
- **Ordering and integrity:** bytes leave in FIFO order with no loss or duplication. The skid buffer never overflows.
- **Empty FIFO:** `fifo_rd_en` is never asserted while `fifo_empty` is high. If the FIFO empties mid-burst, popping stalls until data arrives.
- **Busy:** `busy` is high in BURST and low in IDLE.
- **Counter widths:** `issue_rem` and `out_rem` are BUF_WIDTH+1 bits. `fifo_count` is compared unsigned.
- **Reset:**
  - All outputs go to 0, the state goes to IDLE, and the skid buffer, counters and `inflight` are cleared.
  - Reset mid-burst discards any in-flight or buffered bytes. Those bytes are already removed from the FIFO; this loss is accepted.

## Timing
- `fifo_rd_en` high at cycle N gives `fifo_data` valid at N+1; the skid captures it at the end of N+1. `m_valid` rises at N+2, a two-cycle pop-to-output latency.
- With `m_ready` held high, the block sustains one beat per cycle. A burst of L beats takes `L+2` cycles from the first `fifo_rd_en` to the `m_last` handshake.
- The start condition is sampled in IDLE. The first `fifo_rd_en` is asserted in the cycle after the transition to BURST.
- `m_ready` low stalls popping within at most 2 pops. Releasing it resumes popping in the same cycle.
- No combinational path from `m_ready` to `m_valid`, `m_data` or `m_last`.
- `fifo_rd_en` depends combinationally on `m_ready`, `fifo_empty` and registered state only.

## Structure
- Package `fifo_pkg` holds:
  - the `DATA_W` and `BUF_WIDTH` defaults shared with the FIFO;
  - the two-state `drain_state_t` enum.
- Sub-module `fifo_skid2` is the 2-entry in-order buffer with ports push/data_in, head/occ and pop.
- The top level holds the FSM, the counters and the pop-rule logic.

## Test plan
- **Reset:** hold `rst_n` low with `fifo_count=8`. Expect `fifo_rd_en=0`, `m_valid=0`, `m_last=0`, `busy=0`, and no pops after release until evaluated in IDLE.
- **Single burst:** `fifo_count=4` holding 0x11, 0x12, 0x13, 0x14, `m_ready=1`. Expect 4 consecutive `fifo_rd_en`, then beats 0x11 to 0x14 on 4 consecutive cycles starting 2 cycles after the first pop, `m_last` only on 0x14, then IDLE.
- **Flush:** `fifo_count=3` with 0xA0 to 0xA2 and no flush. Expect no pop for 20 cycles. Pulse `flush`: expect a 3-beat burst with `m_last` on 0xA2.
- **Backpressure:** 4-beat burst with `m_ready` pattern 1,0,1,0,... Expect order 0x11 to 0x14 preserved, exactly 4 pops, skid occupancy never above 2, and `m_data` stable while `m_valid && !m_ready`.
- **Back-to-back bursts:** `fifo_count=8` holding 0x01 to 0x08, `m_ready=1`. Expect two bursts with `m_last` on 0x04 and 0x08 and at least one IDLE cycle between them.
- **Reset mid-burst:** assert `rst_n` low after 2 beats accepted. Expect all outputs 0 at once and `busy=0`. After release, the next burst starts only from the new `fifo_count`.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO widths and drain controller state type
package fifo_pkg;

  localparam int FIFO_DATA_W    = 8;
  localparam int FIFO_BUF_WIDTH = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } drain_state_t;

endpackage

// File: rtl/fifo_skid2.sv
// rtl/fifo_skid2.sv - two-entry in-order buffer between FIFO read port and output stream
module fifo_skid2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;

  assign head = r_mem[r_rd_ptr];
  assign occ  = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= data_in;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - pops a registered-read FIFO and re-emits bytes in framed bursts
module fifo_burst_drain
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int BUF_WIDTH = FIFO_BUF_WIDTH,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fifo_empty,
  input  logic [BUF_WIDTH:0] fifo_count,
  input  logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_rd_en,
  input  logic               flush,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic               busy
);

  localparam logic [BUF_WIDTH:0] L_BURST = (BUF_WIDTH + 1)'(BURST_LEN);

  drain_state_t       r_state;
  drain_state_t       w_state_nxt;
  logic [BUF_WIDTH:0] r_issue_rem;
  logic [BUF_WIDTH:0] r_out_rem;
  logic               r_inflight;

  logic [1:0]         w_occ;
  logic [DATA_W-1:0]  w_head;
  logic               w_pop_now;
  logic               w_room;
  logic               w_norm_start;
  logic               w_flush_start;
  logic [BUF_WIDTH:0] w_start_len;

  fifo_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (r_inflight),
    .data_in (fifo_data),
    .pop     (w_pop_now),
    .head    (w_head),
    .occ     (w_occ)
  );

  assign m_valid   = (w_occ != 2'd0);
  assign m_data    = w_head;
  assign m_last    = m_valid && (r_out_rem == (BUF_WIDTH + 1)'(1));
  assign busy      = (r_state == ST_BURST);
  assign w_pop_now = m_valid && m_ready;

  // Counts bytes already buffered plus the one on the FIFO read port, net of this cycle's beat.
  assign w_room = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop_now});

  assign fifo_rd_en = busy && (r_issue_rem != '0) && !fifo_empty && w_room;

  assign w_norm_start  = (fifo_count >= L_BURST);
  assign w_flush_start = flush && !fifo_empty && !w_norm_start;
  assign w_start_len   = w_norm_start ? L_BURST : fifo_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_norm_start || w_flush_start) w_state_nxt = ST_BURST;
      ST_BURST: if (w_pop_now && m_last)           w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_issue_rem <= '0;
      r_out_rem   <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= fifo_rd_en;
      if (r_state == ST_IDLE && w_state_nxt == ST_BURST) begin
        r_issue_rem <= w_start_len;
        r_out_rem   <= w_start_len;
      end else begin
        if (fifo_rd_en) r_issue_rem <= r_issue_rem - (BUF_WIDTH + 1)'(1);
        if (w_pop_now)  r_out_rem   <= r_out_rem - (BUF_WIDTH + 1)'(1);
      end
    end
  end

endmodule
